// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for flag_branch_sequencer and branch_cond:
//   - sequencer state enumeration
//   - opcode class field values and the HLT opcode
//   - jump condition codes (COND_ALWAYS .. COND_NEVER)
//   - the two ALU operation codes the sequencer itself refers to
// -----------------------------------------------------------------------------
package seq_pkg;

  localparam int OPCODE_W = 6;
  localparam int ADDR_W   = 8;
  localparam int ALU_OP_W = 4;

  typedef enum logic [2:0] {
    ST_FETCH       = 3'd0,
    ST_DECODE      = 3'd1,
    ST_EXEC_ALU    = 3'd2,
    ST_JMP_OPERAND = 3'd3,
    ST_JMP_RESOLVE = 3'd4,
    ST_HALT        = 3'd5
  } state_e;

  // Opcode class lives in the top two opcode bits.
  localparam logic [1:0] CLASS_ALU = 2'b00;
  localparam logic [1:0] CLASS_JMP = 2'b01;

  localparam logic [OPCODE_W-1:0] OP_HLT = 6'b11_1111;

  // Jump condition codes, opcode bits [2:0] of a 01_0ccc instruction.
  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_NZ     = 3'b010;
  localparam logic [2:0] COND_C      = 3'b011;
  localparam logic [2:0] COND_NC     = 3'b100;
  localparam logic [2:0] COND_ODD    = 3'b101;
  localparam logic [2:0] COND_EVEN   = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;

  // ALU_CHK is the idle ALU operation driven whenever no ALU instruction
  // executes; ALU_ADD is opcode 00_0000.
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_CHK = 4'hF;

endpackage

// File: rtl/flag_branch_sequencer_branch_cond.sv
// -----------------------------------------------------------------------------
// branch_cond
// Purely combinational jump-condition evaluator.
// Ports:
//   ccc      in  3  condition code (COND_* in seq_pkg)
//   i_zero   in  1  latched zero flag
//   i_carry  in  1  latched carry flag
//   i_odd    in  1  latched odd flag
//   taken    out 1  condition holds, jump should be taken
// -----------------------------------------------------------------------------
module branch_cond
  import seq_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       i_zero,
  input  logic       i_carry,
  input  logic       i_odd,
  output logic       taken
);

  always_comb begin
    // NOTE: default assignment first so every path drives taken; without it an
    // incomplete case would infer a latch.
    taken = 1'b0;
    unique case (ccc)
      COND_ALWAYS: taken = 1'b1;
      COND_Z:      taken = i_zero;
      COND_NZ:     taken = ~i_zero;
      COND_C:      taken = i_carry;
      COND_NC:     taken = ~i_carry;
      COND_ODD:    taken = i_odd;
      COND_EVEN:   taken = ~i_odd;
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_sequencer.sv
// -----------------------------------------------------------------------------
// flag_branch_sequencer
// Instruction sequencer: fetches an opcode, drives the ALU op and flag-latch
// strobe for ALU instructions, and turns latched ALU flags into a PC load for
// conditional jumps. Sole driver of the ALU op select and flag-latch strobe.
//
// Optional feature: define FLAG_BRANCH_TRACE_EN to add o_taken_count, a
// saturating count of taken jumps.
//
// Ports:
//   clk, rst_n     clock (rising edge), async active-low reset
//   clk_en         step enable; state and registers hold while low
//   i_opcode       instruction register contents, valid from DECODE on
//   i_operand      jump target from memory, valid in JMP_OPERAND
//   i_zero/i_carry/i_odd  latched ALU flags
//   o_ir_load      load instruction register          (FETCH)
//   o_pc_inc       increment PC                        (FETCH, JMP_OPERAND)
//   o_pc_load      load PC from o_pc_target            (JMP_RESOLVE, if taken)
//   o_pc_target    captured jump target
//   o_alu_op       ALU op select, ALU_CHK outside EXEC_ALU
//   o_latch_flags  ALU flag-latch strobe               (EXEC_ALU)
//   o_halted       sequencer in HALT
//   o_taken_count  [FLAG_BRANCH_TRACE_EN] saturating taken-jump count
// Strobes are Moore-decoded and are qualified with clk_en downstream.
// -----------------------------------------------------------------------------
module flag_branch_sequencer
  import seq_pkg::*;
#(
  parameter int OPCODE_WIDTH = OPCODE_W,
  parameter int ADDR_WIDTH   = ADDR_W,
  parameter int ALU_OP_WIDTH = ALU_OP_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic [ADDR_WIDTH-1:0]   i_operand,
  input  logic                    i_zero,
  input  logic                    i_carry,
  input  logic                    i_odd,
  output logic                    o_ir_load,
  output logic                    o_pc_inc,
  output logic                    o_pc_load,
  output logic [ADDR_WIDTH-1:0]   o_pc_target,
  output logic [ALU_OP_WIDTH-1:0] o_alu_op,
  output logic                    o_latch_flags,
  output logic                    o_halted
`ifdef FLAG_BRANCH_TRACE_EN
  ,
  output logic [15:0]             o_taken_count
`endif
);

  state_e                  state_q;
  // Only the low bits are needed after DECODE: ALU op, or condition code.
  logic [ALU_OP_WIDTH-1:0] opcode_q;
  logic [ADDR_WIDTH-1:0]   target_q;
  logic                    cond_taken;

  wire [1:0] op_class = i_opcode[OPCODE_WIDTH-1 -: 2];
  wire       is_jump  = (op_class == CLASS_JMP) && !i_opcode[3];

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      opcode_q <= '0;
      target_q <= '0;
    end else if (clk_en || state_q == ST_HALT) begin
      unique case (state_q)
        ST_FETCH:  state_q <= ST_DECODE;
        ST_DECODE: begin
          opcode_q <= i_opcode[ALU_OP_WIDTH-1:0];
          if (op_class == CLASS_ALU)  state_q <= ST_EXEC_ALU;
          else if (is_jump)           state_q <= ST_JMP_OPERAND;
          else if (i_opcode == OP_HLT) state_q <= ST_HALT;
          else                        state_q <= ST_FETCH;
        end
        ST_EXEC_ALU: state_q <= ST_FETCH;
        ST_JMP_OPERAND: begin
          target_q <= i_operand;
          state_q  <= ST_JMP_RESOLVE;
        end
        ST_JMP_RESOLVE: state_q <= ST_FETCH;
        ST_HALT:        state_q <= ST_HALT;  // terminal until reset
        default:        state_q <= ST_FETCH;
      endcase
    end
  end

  branch_cond u_branch_cond (
    .ccc     (opcode_q[2:0]),
    .i_zero  (i_zero),
    .i_carry (i_carry),
    .i_odd   (i_odd),
    .taken   (cond_taken)
  );

  // Moore decode from the state register and registered opcode. Flags are
  // read only in JMP_RESOLVE, where o_latch_flags is never asserted.
  always_comb begin
    o_ir_load     = 1'b0;
    o_pc_inc      = 1'b0;
    o_pc_load     = 1'b0;
    o_alu_op      = ALU_CHK;
    o_latch_flags = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        o_ir_load = 1'b1;
        o_pc_inc  = 1'b1;
      end
      ST_EXEC_ALU: begin
        o_latch_flags = 1'b1;
        o_alu_op      = opcode_q;
      end
      ST_JMP_OPERAND: o_pc_inc  = 1'b1;
      ST_JMP_RESOLVE: o_pc_load = cond_taken;
      default: ;
    endcase
  end

  assign o_pc_target = target_q;
  assign o_halted    = (state_q == ST_HALT);

`ifdef FLAG_BRANCH_TRACE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_taken_count <= '0;
    end else if (clk_en && o_pc_load && o_taken_count != 16'hFFFF) begin
      o_taken_count <= o_taken_count + 16'd1;
    end
  end
`endif

endmodule
